// File: rtl/dma_wr_pkg.sv
// Shared types and constants for the descriptor-driven AXIS-to-AXI4 write engine.
package dma_wr_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_RESP,
        S_DRAIN,
        S_STATUS
    } state_t;

    localparam int unsigned E_BRESP = 0;
    localparam int unsigned E_SHORT = 1;
    localparam int unsigned E_LONG  = 2;
    localparam int unsigned E_ZERO  = 3;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] RESP_OKAY  = 2'b00;

endpackage

// File: rtl/dma_wr_burst_calc.sv
// Beats for the next burst: min of remaining beats, the burst cap and the room left in the 4 KB page.
module dma_wr_burst_calc #(
    parameter int unsigned LEN_W           = 32,
    parameter int unsigned BYTES           = 4,
    parameter int unsigned MAX_BURST_BEATS = 16
) (
    input  logic [11:0]      page_off,
    input  logic [LEN_W-1:0] beats_rem,
    output logic [8:0]       burst
);
    import dma_wr_pkg::*;

    localparam int unsigned SIZE = $clog2(BYTES);

    logic [12:0] page_beats;
    logic [12:0] cap;

    always_comb begin
        page_beats = (13'h1000 - {1'b0, page_off}) >> SIZE;
        cap        = (page_beats < 13'(MAX_BURST_BEATS)) ? page_beats : 13'(MAX_BURST_BEATS);
        burst      = (LEN_W'(cap) < beats_rem) ? 9'(cap) : 9'(beats_rem);
    end

endmodule

// File: rtl/dma_wr_desc_engine.sv
// Descriptor-driven AXIS-to-AXI4 write engine with one-cycle status pulse.
// Optional DMA_WR_STATUS_BYTES_EN adds m_os_bytes (committed byte count).
module dma_wr_desc_engine
    import dma_wr_pkg::*;
#(
    parameter int unsigned AXI_ADDR_WIDTH  = 32,
    parameter int unsigned AXI_DATA_WIDTH  = 32,
    parameter int unsigned AXI_LEN_WIDTH   = 32,
    parameter int unsigned AXI_TAG_WIDTH   = 8,
    parameter int unsigned MAX_BURST_BEATS = 16
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic [AXI_ADDR_WIDTH-1:0]   s_desc_addr,
    input  logic [AXI_LEN_WIDTH-1:0]    s_desc_len,
    input  logic [AXI_TAG_WIDTH-1:0]    s_desc_tag,
    input  logic                        s_desc_valid,
    output logic                        s_desc_ready,
    input  logic [AXI_DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic                        s_axis_tvalid,
    input  logic                        s_axis_tlast,
    output logic                        s_axis_tready,
    output logic [AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic [7:0]                  m_axi_awlen,
    output logic [2:0]                  m_axi_awsize,
    output logic [1:0]                  m_axi_awburst,
    output logic                        m_axi_awvalid,
    input  logic                        m_axi_awready,
    output logic [AXI_DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                        m_axi_wlast,
    output logic                        m_axi_wvalid,
    input  logic                        m_axi_wready,
    input  logic [1:0]                  m_axi_bresp,
    input  logic                        m_axi_bvalid,
    output logic                        m_axi_bready,
    output logic [AXI_TAG_WIDTH-1:0]    m_os_tag,
    output logic [3:0]                  m_os_error,
`ifdef DMA_WR_STATUS_BYTES_EN
    output logic [AXI_LEN_WIDTH-1:0]    m_os_bytes,
`endif
    output logic                        m_os_valid
);

    localparam int unsigned BYTES = AXI_DATA_WIDTH / 8;
    localparam int unsigned SIZE  = $clog2(BYTES);
    localparam int unsigned AW    = AXI_ADDR_WIDTH;
    localparam int unsigned LW    = AXI_LEN_WIDTH;

    state_t             state_q, state_d;
    logic [AW-1:0]      addr_q;
    logic [AXI_TAG_WIDTH-1:0] tag_q;
    logic [3:0]         err_q;
    logic [SIZE-1:0]    len_mod_q;
    logic [LW-1:0]      beats_rem_q;
    logic [8:0]         burst_q;
    logic [8:0]         burst_len_q;
    logic               short_q;
    logic               tlast_q;
    logic               ready_q, awvalid_q, bready_q, os_valid_q;
    logic [8:0]         burst;
    logic [BYTES-1:0]   strb_all, strb_mask;
    logic               desc_hs, aw_hs, w_hs, b_hs, drain_hs;
    logic               final_burst_beat, final_desc_beat;

    dma_wr_burst_calc #(
        .LEN_W           (LW),
        .BYTES           (BYTES),
        .MAX_BURST_BEATS (MAX_BURST_BEATS)
    ) u_burst_calc (
        .page_off  (addr_q[11:0]),
        .beats_rem (beats_rem_q),
        .burst     (burst)
    );

    assign s_desc_ready  = ready_q;
    assign m_axi_awvalid = awvalid_q;
    assign m_axi_bready  = bready_q;
    assign m_os_valid    = os_valid_q;
    assign m_axi_awaddr  = addr_q;
    assign m_axi_awlen   = awvalid_q ? 8'(burst - 9'd1) : 8'd0;
    assign m_axi_awsize  = 3'(SIZE);
    assign m_axi_awburst = BURST_INCR;
    assign m_os_tag      = os_valid_q ? tag_q : '0;
    assign m_os_error    = os_valid_q ? err_q : 4'd0;

    assign desc_hs  = ready_q && s_desc_valid;
    assign aw_hs    = awvalid_q && m_axi_awready;
    assign w_hs     = m_axi_wvalid && m_axi_wready;
    assign b_hs     = bready_q && m_axi_bvalid;
    assign drain_hs = (state_q == S_DRAIN) && s_axis_tvalid;

    assign final_burst_beat = (burst_q == 9'd1);
    assign final_desc_beat  = final_burst_beat && (beats_rem_q == '0) && !short_q;
    assign strb_all         = '1;
    assign strb_mask        = ~(strb_all << len_mod_q);

    // W channel is a passthrough of the stream; after an early tlast it pads the burst with null beats.
    always_comb begin
        m_axi_wvalid  = 1'b0;
        m_axi_wdata   = '0;
        m_axi_wstrb   = '0;
        m_axi_wlast   = 1'b0;
        s_axis_tready = 1'b0;
        if (state_q == S_DATA) begin
            m_axi_wlast = final_burst_beat;
            if (short_q) begin
                m_axi_wvalid = 1'b1;
            end else begin
                m_axi_wvalid  = s_axis_tvalid;
                s_axis_tready = m_axi_wready;
                m_axi_wdata   = s_axis_tdata;
                m_axi_wstrb   = (final_desc_beat && len_mod_q != '0) ? strb_mask : strb_all;
            end
        end else if (state_q == S_DRAIN) begin
            s_axis_tready = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (desc_hs) state_d = (s_desc_len == '0) ? S_STATUS : S_ADDR;
            S_ADDR:   if (aw_hs) state_d = S_DATA;
            S_DATA:   if (w_hs && final_burst_beat) state_d = S_RESP;
            S_RESP: begin
                if (b_hs) begin
                    if (beats_rem_q != '0 && !short_q) state_d = S_ADDR;
                    else if (!short_q && !tlast_q)     state_d = S_DRAIN;
                    else                               state_d = S_STATUS;
                end
            end
            S_DRAIN:  if (drain_hs && s_axis_tlast) state_d = S_STATUS;
            S_STATUS: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= S_IDLE;
            ready_q    <= 1'b0;
            awvalid_q  <= 1'b0;
            bready_q   <= 1'b0;
            os_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ready_q    <= (state_d == S_IDLE);
            awvalid_q  <= (state_d == S_ADDR);
            bready_q   <= (state_d == S_RESP);
            os_valid_q <= (state_d == S_STATUS);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            addr_q      <= '0;
            tag_q       <= '0;
            err_q       <= 4'd0;
            len_mod_q   <= '0;
            beats_rem_q <= '0;
            burst_q     <= 9'd0;
            burst_len_q <= 9'd0;
            short_q     <= 1'b0;
            tlast_q     <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: if (desc_hs) begin
                    addr_q      <= s_desc_addr & ~AW'(BYTES - 1);
                    tag_q       <= s_desc_tag;
                    len_mod_q   <= s_desc_len[SIZE-1:0];
                    beats_rem_q <= (s_desc_len >> SIZE) + LW'(|s_desc_len[SIZE-1:0]);
                    err_q       <= 4'd0;
                    err_q[E_ZERO] <= (s_desc_len == '0);
                    short_q     <= 1'b0;
                    tlast_q     <= 1'b0;
                end
                S_ADDR: if (aw_hs) begin
                    burst_q     <= burst;
                    burst_len_q <= burst;
                    beats_rem_q <= beats_rem_q - LW'(burst);
                end
                S_DATA: if (w_hs) begin
                    if (burst_q != 9'd0) burst_q <= burst_q - 9'd1;
                    // A tlast before the descriptor's last beat ends the transfer early.
                    if (!short_q && s_axis_tlast && !final_desc_beat) begin
                        short_q        <= 1'b1;
                        err_q[E_SHORT] <= 1'b1;
                    end
                    if (final_desc_beat) tlast_q <= s_axis_tlast;
                end
                S_RESP: if (b_hs) begin
                    if (m_axi_bresp != RESP_OKAY) err_q[E_BRESP] <= 1'b1;
                    if (!tlast_q && beats_rem_q == '0 && !short_q) err_q[E_LONG] <= 1'b1;
                    addr_q <= addr_q + (AW'(burst_len_q) << SIZE);
                end
                default: ;
            endcase
        end
    end

`ifdef DMA_WR_STATUS_BYTES_EN
    logic [LW-1:0] bytes_q;

    // Committed bytes = popcount of strobes on accepted beats; padded beats contribute nothing.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bytes_q <= '0;
        end else if (desc_hs) begin
            bytes_q <= '0;
        end else if (state_q == S_DATA && w_hs && !short_q) begin
            bytes_q <= bytes_q + ((final_desc_beat && len_mod_q != '0) ? LW'(len_mod_q) : LW'(BYTES));
        end
    end

    assign m_os_bytes = os_valid_q ? bytes_q : '0;
`endif

endmodule

// File: tb/tb_dma_wr_desc_engine.sv
// Randomized scoreboard bench for dma_wr_desc_engine against a transaction-level reference model.
module tb_dma_wr_desc_engine;

    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] s_desc_addr;
    logic [31:0] s_desc_len;
    logic [7:0]  s_desc_tag;
    logic        s_desc_valid;
    logic        s_desc_ready;
    logic [31:0] s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tlast;
    logic        s_axis_tready;
    logic [31:0] m_axi_awaddr;
    logic [7:0]  m_axi_awlen;
    logic [2:0]  m_axi_awsize;
    logic [1:0]  m_axi_awburst;
    logic        m_axi_awvalid;
    logic        m_axi_awready;
    logic [31:0] m_axi_wdata;
    logic [3:0]  m_axi_wstrb;
    logic        m_axi_wlast;
    logic        m_axi_wvalid;
    logic        m_axi_wready;
    logic [1:0]  m_axi_bresp;
    logic        m_axi_bvalid;
    logic        m_axi_bready;
    logic [7:0]  m_os_tag;
    logic [3:0]  m_os_error;
    logic        m_os_valid;
`ifdef DMA_WR_STATUS_BYTES_EN
    logic [31:0] m_os_bytes;
`endif

    dma_wr_desc_engine dut (
        .clk           (clk),
        .rstn          (rstn),
        .s_desc_addr   (s_desc_addr),
        .s_desc_len    (s_desc_len),
        .s_desc_tag    (s_desc_tag),
        .s_desc_valid  (s_desc_valid),
        .s_desc_ready  (s_desc_ready),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tready (s_axis_tready),
        .m_axi_awaddr  (m_axi_awaddr),
        .m_axi_awlen   (m_axi_awlen),
        .m_axi_awsize  (m_axi_awsize),
        .m_axi_awburst (m_axi_awburst),
        .m_axi_awvalid (m_axi_awvalid),
        .m_axi_awready (m_axi_awready),
        .m_axi_wdata   (m_axi_wdata),
        .m_axi_wstrb   (m_axi_wstrb),
        .m_axi_wlast   (m_axi_wlast),
        .m_axi_wvalid  (m_axi_wvalid),
        .m_axi_wready  (m_axi_wready),
        .m_axi_bresp   (m_axi_bresp),
        .m_axi_bvalid  (m_axi_bvalid),
        .m_axi_bready  (m_axi_bready),
        .m_os_tag      (m_os_tag),
        .m_os_error    (m_os_error),
`ifdef DMA_WR_STATUS_BYTES_EN
        .m_os_bytes    (m_os_bytes),
`endif
        .m_os_valid    (m_os_valid)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit ignore = 1'b0;
    bit bad_cur = 1'b0;
    bit b_pend = 1'b0;
    bit aw_open = 1'b0;

    logic [39:0] exp_aw[$];   // {addr, awlen}
    logic [36:0] exp_w[$];    // {data, strb, last}
    logic [43:0] exp_st[$];   // {tag, error, bytes}

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic timeout_fail(input string nm);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: timed out", nm);
    endtask

    // AXI slave: random ready stalls, one B response per burst.
    initial begin
        m_axi_awready = 1'b0;
        m_axi_wready  = 1'b0;
        m_axi_bvalid  = 1'b0;
        m_axi_bresp   = 2'b00;
        forever begin
            @(posedge clk);
            #1;
            m_axi_awready = ($urandom % 3) != 0;
            m_axi_wready  = ($urandom % 4) != 0;
            m_axi_bvalid  = b_pend && (($urandom % 2) != 0);
            m_axi_bresp   = bad_cur ? 2'b10 : 2'b00;
        end
    end

    initial forever begin
        @(negedge clk);
        if (!rstn) begin
            b_pend = 1'b0;
        end else begin
            if (m_axi_bvalid && m_axi_bready) b_pend = 1'b0;
            if (m_axi_wvalid && m_axi_wready && m_axi_wlast) b_pend = 1'b1;
        end
    end

    // Monitor: compare every AW, W and status transfer against the scoreboard queues.
    initial forever begin
        logic [39:0] a;
        logic [36:0] w;
        logic [43:0] s;
        @(negedge clk);
        if (!rstn) aw_open = 1'b0;
        if (rstn && !ignore) begin
            if (m_axi_awvalid && m_axi_awready) begin
                check("aw_single_outstanding", 64'(aw_open), 64'd0);
                aw_open = 1'b1;
                if (exp_aw.size() == 0) begin
                    check("aw_unexpected", 64'(m_axi_awaddr), 64'hFFFF_FFFF_FFFF);
                end else begin
                    a = exp_aw.pop_front();
                    check("awaddr", 64'(m_axi_awaddr), 64'(a[39:8]));
                    check("awlen", 64'(m_axi_awlen), 64'(a[7:0]));
                    check("awsize", 64'(m_axi_awsize), 64'd2);
                    check("awburst", 64'(m_axi_awburst), 64'd1);
                end
            end
            if (m_axi_wvalid && m_axi_wready) begin
                check("w_after_aw", 64'(aw_open), 64'd1);
                if (exp_w.size() == 0) begin
                    check("w_unexpected", 64'(m_axi_wdata), 64'hFFFF_FFFF_FFFF);
                end else begin
                    w = exp_w.pop_front();
                    check("wdata", 64'(m_axi_wdata), 64'(w[36:5]));
                    check("wstrb", 64'(m_axi_wstrb), 64'(w[4:1]));
                    check("wlast", 64'(m_axi_wlast), 64'(w[0]));
                end
                if (m_axi_wlast) aw_open = 1'b0;
            end
            if (m_os_valid) begin
                if (exp_st.size() == 0) begin
                    check("status_unexpected", 64'(m_os_tag), 64'hFFFF_FFFF_FFFF);
                end else begin
                    s = exp_st.pop_front();
                    check("os_tag", 64'(m_os_tag), 64'(s[43:36]));
                    check("os_error", 64'(m_os_error), 64'(s[35:32]));
`ifdef DMA_WR_STATUS_BYTES_EN
                    check("os_bytes", 64'(m_os_bytes), 64'(s[31:0]));
`endif
                end
            end
        end
    end

    task automatic drive_desc(input logic [31:0] a, input logic [31:0] len, input logic [7:0] tag);
        int t = 0;
        @(posedge clk);
        #1;
        s_desc_addr  = a;
        s_desc_len   = len;
        s_desc_tag   = tag;
        s_desc_valid = 1'b1;
        do begin
            @(negedge clk);
            t++;
        end while (!s_desc_ready && t < 1000);
        if (!s_desc_ready) timeout_fail("desc_ready");
        @(posedge clk);
        #1;
        s_desc_valid = 1'b0;
    endtask

    task automatic drive_beat(input logic [31:0] d, input bit last);
        int t = 0;
        int gap = $urandom % 3;
        for (int i = 0; i < gap; i++) begin
            @(posedge clk);
            #1;
        end
        s_axis_tdata  = d;
        s_axis_tlast  = last;
        s_axis_tvalid = 1'b1;
        do begin
            @(negedge clk);
            t++;
        end while (!s_axis_tready && t < 1000);
        if (!s_axis_tready) timeout_fail("tready");
        @(posedge clk);
        #1;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    // Reference model: splits the descriptor into page-safe bursts and predicts every transfer.
    task automatic run_desc(input logic [31:0] a_in, input int len, input logic [7:0] tag,
                            input int s_beats, input bit bad);
        int n = (len + 3) / 4;
        int rem = n;
        int g = 0;
        int b;
        int room;
        int t = 0;
        longint a = longint'(a_in) & ~longint'(3);
        bit short_m = (s_beats < n);
        bit long_m = (s_beats > n);
        logic [3:0] err = 4'd0;
        logic [3:0] strb;
        logic [31:0] d[$];
        for (int i = 0; i < s_beats; i++) d.push_back($urandom);
        bad_cur = bad;
        while (rem > 0) begin
            room = (4096 - int'(a % 4096)) / 4;
            b = rem;
            if (b > 16) b = 16;
            if (b > room) b = room;
            exp_aw.push_back({32'(a), 8'(b - 1)});
            for (int j = 0; j < b; j++) begin
                g++;
                if (short_m && g > s_beats) begin
                    exp_w.push_back({32'd0, 4'd0, j == b - 1});
                end else begin
                    strb = (g == n && (len % 4) != 0) ? 4'((1 << (len % 4)) - 1) : 4'hF;
                    exp_w.push_back({d[g-1], strb, j == b - 1});
                end
            end
            rem -= b;
            a += longint'(b * 4);
            if (bad) err[0] = 1'b1;
            if (short_m && g >= s_beats) break;
        end
        if (len == 0) err[3] = 1'b1;
        if (short_m)  err[1] = 1'b1;
        if (long_m)   err[2] = 1'b1;
        exp_st.push_back({tag, err, 32'(short_m ? s_beats * 4 : len)});
        drive_desc(a_in, 32'(len), tag);
        for (int i = 0; i < s_beats; i++) drive_beat(d[i], i == s_beats - 1);
        while ((exp_st.size() != 0 || exp_w.size() != 0 || exp_aw.size() != 0) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 3000) begin
            timeout_fail("desc_complete");
            exp_st.delete();
            exp_w.delete();
            exp_aw.delete();
        end
    endtask

    initial begin
        int len;
        int n;
        int s;
        logic [31:0] a;
        rstn          = 1'b0;
        s_desc_addr   = '0;
        s_desc_len    = '0;
        s_desc_tag    = '0;
        s_desc_valid  = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_desc_ready", 64'(s_desc_ready), 64'd0);
        check("rst_awvalid", 64'(m_axi_awvalid), 64'd0);
        check("rst_wvalid", 64'(m_axi_wvalid), 64'd0);
        check("rst_bready", 64'(m_axi_bready), 64'd0);
        check("rst_tready", 64'(s_axis_tready), 64'd0);
        check("rst_os_valid", 64'(m_os_valid), 64'd0);
        check("rst_awsize", 64'(m_axi_awsize), 64'd2);
        check("rst_awburst", 64'(m_axi_awburst), 64'd1);
        @(posedge clk);
        #1;
        rstn = 1'b1;

        run_desc(32'h0000_1000, 64, 8'd5, 16, 1'b0);
        run_desc(32'h0000_0FF8, 32, 8'd1, 8, 1'b0);
        run_desc(32'h0000_2000, 10, 8'd2, 3, 1'b0);
        run_desc(32'h0000_3000, 64, 8'd3, 4, 1'b0);
        run_desc(32'h0000_4000, 16, 8'd4, 6, 1'b0);
        run_desc(32'h0000_5000, 16, 8'd6, 4, 1'b1);
        run_desc(32'h0000_6000, 0, 8'd9, 0, 1'b0);
        run_desc(32'h0000_7FFC, 7, 8'd10, 2, 1'b0);

        for (int k = 0; k < 40; k++) begin
            a = $urandom & 32'h0000_FFFF;
            if (($urandom % 2) != 0) a = (a | 32'h0000_0FFF) - ($urandom % 80);
            len = (($urandom % 10) == 0) ? 0 : int'($urandom % 200) + 1;
            n = (len + 3) / 4;
            s = (len == 0) ? 0 : n + int'($urandom_range(0, 4)) - 2;
            if (len != 0 && s < 1) s = 1;
            run_desc(a, len, 8'(k + 16), s, ($urandom % 6) == 0);
        end

        // Reset in the middle of a data phase.
        ignore = 1'b1;
        drive_desc(32'h0000_9000, 32'd64, 8'd7);
        begin
            int t = 0;
            @(posedge clk);
            #1;
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = 32'hDEAD_BEEF;
            do begin
                @(negedge clk);
                t++;
            end while (!m_axi_wvalid && t < 200);
            if (!m_axi_wvalid) timeout_fail("reach_data");
        end
        @(posedge clk);
        #1;
        rstn          = 1'b0;
        s_axis_tvalid = 1'b0;
        #1;
        check("midrst_awvalid", 64'(m_axi_awvalid), 64'd0);
        check("midrst_wvalid", 64'(m_axi_wvalid), 64'd0);
        check("midrst_bready", 64'(m_axi_bready), 64'd0);
        check("midrst_tready", 64'(s_axis_tready), 64'd0);
        check("midrst_os_valid", 64'(m_os_valid), 64'd0);
        check("midrst_desc_ready", 64'(s_desc_ready), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("postrst_idle_ready", 64'(s_desc_ready), 64'd1);
        ignore = 1'b0;
        bad_cur = 1'b0;
        run_desc(32'h0000_A004, 20, 8'd11, 5, 1'b0);

        check("aw_queue_empty", 64'(exp_aw.size()), 64'd0);
        check("w_queue_empty", 64'(exp_w.size()), 64'd0);
        check("st_queue_empty", 64'(exp_st.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
